// File: rtl/servo_motion_ctrl_pkg.sv
// Shared constants for the pan/tilt servo sequencer: register offsets, modes and bit positions.
package servo_pkg;

   localparam int PW_W_DEF = 21;

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_XTGT     = 3'd1;
   localparam logic [2:0] REG_YTGT     = 3'd2;
   localparam logic [2:0] REG_STEP     = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;
   localparam logic [2:0] REG_XCUR     = 3'd5;
   localparam logic [2:0] REG_YCUR     = 3'd6;
   localparam logic [2:0] REG_UNMAPPED = 3'd7;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_TRACK = 2'b01,
      MODE_SWEEP = 2'b10
   } mode_t;

   localparam int CTRL_MODE_LSB = 0;
   localparam int CTRL_RECENTER = 2;

   localparam int ST_XBUSY  = 0;
   localparam int ST_YBUSY  = 1;
   localparam int ST_XDIR   = 2;
   localparam int ST_YDIR   = 3;
   localparam int ST_PARITY = 4;

endpackage

// File: rtl/servo_motion_ctrl_if.sv
// APB3 slot bundle between CoreAPB3 and the servo sequencer.
interface servo_motion_ctrl_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] PRDATA;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY, PSLVERR, PRDATA
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY, PSLVERR, PRDATA
   );
endinterface

// File: rtl/servo_axis_slew.sv
// One servo axis: rate-limited tracking toward a target, or clamp-and-reverse sweeping,
// advanced once per frame tick.
module servo_axis_slew
   import servo_pkg::*;
#(
   parameter int PW_MIN = 100000,
   parameter int PW_MAX = 200000,
   parameter int PW_W   = PW_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic [1:0]      mode,
   input  logic [PW_W-1:0] target,
   input  logic [15:0]     step,
   input  logic            step_en,
   input  logic            recenter,
   output logic [PW_W-1:0] cur,
   output logic            dir,
   output logic            busy,
   output logic            reversed
);

   // One guard bit above the pulse width keeps cur +/- step from wrapping.
   localparam int AW = PW_W + 1;
   localparam logic [PW_W-1:0]      CENTER = PW_W'((PW_MIN + PW_MAX) / 2);
   localparam logic signed [AW-1:0] PMIN_S = AW'(PW_MIN);
   localparam logic signed [AW-1:0] PMAX_S = AW'(PW_MAX);

   logic signed [AW-1:0] cur_s, tgt_s, step_s, diff_s, next_s;
   logic [PW_W-1:0]      cur_nxt;
   logic                 dir_nxt;

   always_comb begin
      cur_s    = signed'({1'b0, cur});
      tgt_s    = signed'({1'b0, target});
      step_s   = signed'({{(AW-16){1'b0}}, step});
      diff_s   = tgt_s - cur_s;
      next_s   = cur_s;
      cur_nxt  = cur;
      dir_nxt  = dir;
      reversed = 1'b0;
      if (tick && step != 16'd0) begin
         case (mode)
            MODE_TRACK: begin
               if (diff_s > step_s)       next_s = cur_s + step_s;
               else if (diff_s < -step_s) next_s = cur_s - step_s;
               else                       next_s = tgt_s;
               cur_nxt = next_s[PW_W-1:0];
            end
            MODE_SWEEP: begin
               if (step_en) begin
                  next_s = dir ? cur_s + step_s : cur_s - step_s;
                  if (next_s >= PMAX_S) begin
                     cur_nxt  = PW_W'(PW_MAX);
                     dir_nxt  = 1'b0;
                     reversed = 1'b1;
                  end else if (next_s <= PMIN_S) begin
                     cur_nxt  = PW_W'(PW_MIN);
                     dir_nxt  = 1'b1;
                     reversed = 1'b1;
                  end else begin
                     cur_nxt  = next_s[PW_W-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (mode == MODE_TRACK) ? (cur != target) : (mode == MODE_SWEEP);

   // Recenter wins over a same-cycle tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= CENTER;
         dir <= 1'b1;
      end else if (recenter) begin
         cur <= CENTER;
         dir <= 1'b1;
      end else begin
         cur <= cur_nxt;
         dir <= dir_nxt;
      end
   end

endmodule

// File: rtl/servo_motion_ctrl.sv
// Pan/tilt servo sequencer: APB3 register file, PWM frame timer and the X->Y raster
// coupling around two slew axes.
module servo_motion_ctrl
   import servo_pkg::*;
#(
   parameter int PWM_PERIOD = 2000000,
   parameter int PW_MIN     = 100000,
   parameter int PW_MAX     = 200000,
   parameter int PW_W       = PW_W_DEF
) (
   input  logic               PCLK,
   input  logic               PRESET,
   servo_motion_ctrl_if.slave apb,
   output logic [PW_W-1:0]    x_pulse_width,
   output logic [PW_W-1:0]    y_pulse_width,
   output logic               frame_strobe
);

   localparam logic [PW_W-1:0] CENTER   = PW_W'((PW_MIN + PW_MAX) / 2);
   localparam logic [PW_W-1:0] CNT_LAST = PW_W'(PWM_PERIOD - 1);

   logic [1:0]      mode_q;
   logic [PW_W-1:0] x_tgt_q, y_tgt_q, cnt_q, x_cur, y_cur;
   logic [15:0]     step_q;
   logic            parity_q;
   logic [2:0]      offset;
   logic            wr_en, tick, recenter;
   logic            x_dir, y_dir, x_busy, y_busy, x_rev, y_rev;
   logic            unused_ok;

   function automatic logic [PW_W-1:0] clamp_pw(input logic [31:0] v);
      if (v < 32'(PW_MIN))      return PW_W'(PW_MIN);
      else if (v > 32'(PW_MAX)) return PW_W'(PW_MAX);
      else                      return v[PW_W-1:0];
   endfunction

   assign offset    = apb.PADDR[4:2];
   assign wr_en     = apb.PSEL && apb.PENABLE && apb.PWRITE;
   assign recenter  = wr_en && (offset == REG_CTRL) && apb.PWDATA[CTRL_RECENTER];
   assign tick      = (cnt_q == CNT_LAST);
   assign unused_ok = ^{apb.PADDR[31:5], apb.PADDR[1:0], y_rev};

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = apb.PSEL && apb.PENABLE && (offset == REG_UNMAPPED);

   always_comb begin
      apb.PRDATA = '0;
      case (offset)
         REG_CTRL:   apb.PRDATA[CTRL_MODE_LSB +: 2] = mode_q;
         REG_XTGT:   apb.PRDATA[PW_W-1:0] = x_tgt_q;
         REG_YTGT:   apb.PRDATA[PW_W-1:0] = y_tgt_q;
         REG_STEP:   apb.PRDATA[15:0]     = step_q;
         REG_STATUS: begin
            apb.PRDATA[ST_XBUSY]  = x_busy;
            apb.PRDATA[ST_YBUSY]  = y_busy;
            apb.PRDATA[ST_XDIR]   = x_dir;
            apb.PRDATA[ST_YDIR]   = y_dir;
            apb.PRDATA[ST_PARITY] = parity_q;
         end
         REG_XCUR:   apb.PRDATA[PW_W-1:0] = x_cur;
         REG_YCUR:   apb.PRDATA[PW_W-1:0] = y_cur;
         default: ;
      endcase
   end

   // Registers update on the same edge as the axes, so a tick sees pre-write values.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cnt_q        <= '0;
         frame_strobe <= 1'b0;
         parity_q     <= 1'b0;
         mode_q       <= MODE_HOLD;
         step_q       <= 16'd1000;
         x_tgt_q      <= CENTER;
         y_tgt_q      <= CENTER;
      end else begin
         cnt_q        <= tick ? '0 : cnt_q + PW_W'(1);
         frame_strobe <= tick;
         if (tick) parity_q <= ~parity_q;
         if (recenter) begin
            x_tgt_q <= CENTER;
            y_tgt_q <= CENTER;
         end
         if (wr_en) begin
            case (offset)
               REG_CTRL: mode_q  <= apb.PWDATA[CTRL_MODE_LSB +: 2];
               REG_XTGT: x_tgt_q <= clamp_pw(apb.PWDATA);
               REG_YTGT: y_tgt_q <= clamp_pw(apb.PWDATA);
               REG_STEP: step_q  <= apb.PWDATA[15:0];
               default: ;
            endcase
         end
      end
   end

   servo_axis_slew #(.PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_W(PW_W)) u_x_axis (
      .clk(PCLK), .rst(PRESET), .tick(tick), .mode(mode_q), .target(x_tgt_q),
      .step(step_q), .step_en(1'b1), .recenter(recenter),
      .cur(x_cur), .dir(x_dir), .busy(x_busy), .reversed(x_rev)
   );

   // In SWEEP, Y only advances on frames where X bounced off a limit.
   servo_axis_slew #(.PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_W(PW_W)) u_y_axis (
      .clk(PCLK), .rst(PRESET), .tick(tick), .mode(mode_q), .target(y_tgt_q),
      .step(step_q), .step_en(x_rev), .recenter(recenter),
      .cur(y_cur), .dir(y_dir), .busy(y_busy), .reversed(y_rev)
   );

   assign x_pulse_width = x_cur;
   assign y_pulse_width = y_cur;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Bench for servo_motion_ctrl: register vector table, hand-built motion sequences and a
// randomized frame-by-frame comparison against an arithmetic model.
module tb_servo_motion_ctrl;
   import servo_pkg::*;

   localparam int PWM_PERIOD = 100;
   localparam int PW_MIN     = 10;
   localparam int PW_MAX     = 50;
   localparam int PW_W       = 21;
   localparam int CENTER     = 30;

   logic            PCLK = 1'b0;
   logic            PRESET = 1'b1;
   logic [PW_W-1:0] x_pw, y_pw;
   logic            frame_strobe;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   int mx, my, tx, ty, xd, yd, mstep, mmode;

   servo_motion_ctrl_if apb();

   servo_motion_ctrl #(
      .PWM_PERIOD(PWM_PERIOD), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_W(PW_W)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .apb(apb),
      .x_pulse_width(x_pw), .y_pulse_width(y_pw), .frame_strobe(frame_strobe)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        wr;
      logic [2:0]  off;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        exp_err;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [2:0] off, input logic [31:0] d);
      @(posedge PCLK); #1;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
      apb.PADDR = {27'd0, off, 2'b00}; apb.PWDATA = d;
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      @(posedge PCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] off, output logic [31:0] d, output logic err);
      @(posedge PCLK); #1;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      apb.PADDR = {27'd0, off, 2'b00};
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      #1;
      d = apb.PRDATA; err = apb.PSLVERR;
      @(posedge PCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * PWM_PERIOD; i++) begin
         @(posedge PCLK); #1;
         if (frame_strobe) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL strobe_timeout: got no frame_strobe, expected one within %0d cycles", 3 * PWM_PERIOD);
      end
   endtask

   function automatic int clampi(input int v);
      if (v < PW_MIN) return PW_MIN;
      if (v > PW_MAX) return PW_MAX;
      return v;
   endfunction

   function automatic int approach(input int c, input int t, input int s);
      if (t > c) return c + (((t - c) < s) ? (t - c) : s);
      return c - (((c - t) < s) ? (c - t) : s);
   endfunction

   // Move one position by +/-s; bounce off a limit and report it.
   function automatic void bounce(inout int c, inout int d, input int s, output bit rev);
      int n;
      n = d ? c + s : c - s;
      rev = 1'b0;
      if (n >= PW_MAX)      begin c = PW_MAX; d = 0; rev = 1'b1; end
      else if (n <= PW_MIN) begin c = PW_MIN; d = 1; rev = 1'b1; end
      else                  c = n;
   endfunction

   function automatic void model_frame();
      bit rx, ry;
      if (mstep == 0) return;
      if (mmode == 1) begin
         mx = approach(mx, tx, mstep);
         my = approach(my, ty, mstep);
      end else if (mmode == 2) begin
         bounce(mx, xd, mstep, rx);
         if (rx) bounce(my, yd, mstep, ry);
      end
   endfunction

   function automatic void model_recenter();
      mx = CENTER; my = CENTER; tx = CENTER; ty = CENTER; xd = 1; yd = 1;
   endfunction

   initial begin
      logic [31:0] d;
      logic        e;
      bit          ok;
      int          n;
      int          sx[7] = '{40, 50, 40, 30, 20, 10, 20};
      int          sy[7] = '{30, 40, 40, 40, 40, 50, 50};

      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      apb.PADDR = '0; apb.PWDATA = '0;

      vecs[0]  = '{1'b0, REG_STEP,     32'd0,          32'd1000, 1'b0, "step_reset"};
      vecs[1]  = '{1'b0, REG_CTRL,     32'd0,          32'd0,    1'b0, "ctrl_reset"};
      vecs[2]  = '{1'b0, REG_XCUR,     32'd0,          32'd30,   1'b0, "xcur_reset"};
      vecs[3]  = '{1'b1, REG_XTGT,     32'd5,          32'd10,   1'b0, "xtgt_clamp_lo"};
      vecs[4]  = '{1'b1, REG_XTGT,     32'd999,        32'd50,   1'b0, "xtgt_clamp_hi"};
      vecs[5]  = '{1'b1, REG_YTGT,     32'd0,          32'd10,   1'b0, "ytgt_clamp_lo"};
      vecs[6]  = '{1'b1, REG_YTGT,     32'hFFFF_FFFF,  32'd50,   1'b0, "ytgt_clamp_big"};
      vecs[7]  = '{1'b1, REG_XCUR,     32'd12345,      32'd30,   1'b0, "xcur_ro"};
      vecs[8]  = '{1'b1, REG_STEP,     32'h0001_0004,  32'd4,    1'b0, "step_16bit"};
      vecs[9]  = '{1'b1, REG_CTRL,     32'd3,          32'd3,    1'b0, "ctrl_mode3"};
      vecs[10] = '{1'b1, REG_CTRL,     32'd0,          32'd0,    1'b0, "ctrl_hold"};
      vecs[11] = '{1'b0, REG_UNMAPPED, 32'd0,          32'd0,    1'b1, "unmapped"};

      // reset
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_x", x_pw, CENTER);
      check("rst_y", y_pw, CENTER);
      check("rst_strobe", frame_strobe, 0);
      check("rst_pready", apb.PREADY, 1);
      check("rst_pslverr", apb.PSLVERR, 0);
      PRESET = 1'b0;
      n = 0;
      for (int i = 0; i < 3 * PWM_PERIOD; i++) begin
         @(posedge PCLK); #1;
         n++;
         if (frame_strobe) break;
      end
      check("first_strobe_edges", n, PWM_PERIOD);

      // register table
      foreach (vecs[i]) begin
         if (vecs[i].wr) apb_write(vecs[i].off, vecs[i].wdata);
         apb_read(vecs[i].off, d, e);
         check(vecs[i].name, d, vecs[i].exp);
         check({vecs[i].name, "_err"}, e, vecs[i].exp_err);
      end

      // TRACK slew
      wait_strobe(ok);
      apb_write(REG_XTGT, 32'd41);
      apb_write(REG_YTGT, 32'd30);
      apb_write(REG_CTRL, 32'd1);
      wait_strobe(ok);
      check("track_x1", x_pw, 34);
      check("track_y1", y_pw, 30);
      apb_read(REG_STATUS, d, e);
      check("track_busy1", d[ST_XBUSY], 1);
      wait_strobe(ok);
      check("track_x2", x_pw, 38);
      apb.PADDR = {27'd0, REG_XCUR, 2'b00};
      wait_strobe(ok);
      check("track_x3", x_pw, 41);
      check("track_rd_strobe", apb.PRDATA, 41);
      check("track_y3", y_pw, 30);
      apb_read(REG_STATUS, d, e);
      check("track_busy_done", d[ST_XBUSY], 0);

      // SWEEP raster from center
      wait_strobe(ok);
      apb_write(REG_STEP, 32'd10);
      apb_write(REG_CTRL, 32'd6);
      for (int i = 0; i < 7; i++) begin
         wait_strobe(ok);
         check($sformatf("sweep_x%0d", i), x_pw, sx[i]);
         check($sformatf("sweep_y%0d", i), y_pw, sy[i]);
      end
      apb_read(REG_STATUS, d, e);
      check("sweep_status", d[3:0], 7);

      // recenter mid-sweep
      apb_write(REG_CTRL, 32'd6);
      check("recenter_x", x_pw, CENTER);
      check("recenter_y", y_pw, CENTER);
      apb_read(REG_CTRL, d, e);
      check("recenter_mode", d, 2);
      apb_read(REG_STATUS, d, e);
      check("recenter_status", d[3:0], 15);
      apb_read(REG_YTGT, d, e);
      check("recenter_ytgt", d, CENTER);

      // write/tick collision
      apb_write(REG_CTRL, 32'd5);
      apb_write(REG_STEP, 32'd4);
      apb_write(REG_XTGT, 32'd50);
      wait_strobe(ok);
      check("coll_pre_x", x_pw, 34);
      repeat (PWM_PERIOD - 3) @(posedge PCLK);
      apb_write(REG_STEP, 32'd2);
      check("coll_strobe", frame_strobe, 1);
      check("coll_old_step", x_pw, 38);
      wait_strobe(ok);
      check("coll_new_step", x_pw, 40);

      // randomized frames against the model
      wait_strobe(ok);
      apb_write(REG_CTRL, 32'd4);
      apb_write(REG_STEP, 32'd7);
      model_recenter();
      mmode = 0; mstep = 7;
      for (int f = 0; f < 40; f++) begin
         wait_strobe(ok);
         if (!ok) break;
         model_frame();
         check("rnd_x", x_pw, mx);
         check("rnd_y", y_pw, my);
         apb_read(REG_STATUS, d, e);
         check("rnd_xdir", d[ST_XDIR], xd);
         check("rnd_ydir", d[ST_YDIR], yd);
         if (mmode == 1) check("rnd_xbusy", d[ST_XBUSY], (mx != tx) ? 1 : 0);
         if (mmode == 2) check("rnd_ybusy", d[ST_YBUSY], 1);
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) begin
            int v;
            case ($urandom_range(0, 3))
               0: begin
                  v = $urandom_range(0, 3);
                  if ($urandom_range(0, 7) == 0) v = v + 4;
                  apb_write(REG_CTRL, v);
                  mmode = v % 4;
                  if (v >= 4) model_recenter();
               end
               1: begin v = $urandom_range(0, 70); apb_write(REG_XTGT, v); tx = clampi(v); end
               2: begin v = $urandom_range(0, 70); apb_write(REG_YTGT, v); ty = clampi(v); end
               default: begin v = $urandom_range(0, 20); apb_write(REG_STEP, v); mstep = v; end
            endcase
         end
      end

      // reset during an access phase must not commit the write
      @(posedge PCLK); #1;
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
      apb.PADDR = {27'd0, REG_XTGT, 2'b00}; apb.PWDATA = 32'd45;
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      #2 PRESET = 1'b1;
      @(posedge PCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      check("abort_x", x_pw, CENTER);
      check("abort_y", y_pw, CENTER);
      check("abort_strobe", frame_strobe, 0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      apb_read(REG_XTGT, d, e);
      check("abort_xtgt", d, CENTER);
      apb_read(REG_STEP, d, e);
      check("abort_step", d, 1000);
      apb_read(REG_CTRL, d, e);
      check("abort_ctrl", d, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/servo_motion_ctrl.md
# servo_motion_ctrl

APB3 slave that sequences the pan/tilt servo datapath: it holds X/Y target pulse widths, slews the commanded pulse widths toward them at a rate-limited step once per PWM frame, and offers an autonomous raster-sweep mode for target acquisition. It sits on a CoreAPB3 slot beside the servo PWM generator. Its pulse-width outputs and frame strobe feed that generator, which latches them at its own frame start.

## Interface
- PWM_PERIOD, 2000000, frame length in PCLK cycles; must be < 2^PW_W
- PW_MIN, 100000, minimum legal pulse width in clocks
- PW_MAX, 200000, maximum legal pulse width in clocks; PW_MIN < PW_MAX
- PW_W, 21, pulse-width and frame-counter width

Ports:
- PCLK  in  1  fabric clock; all logic on the rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB direction, 1 = write
- PADDR  in  32  APB address; only [4:2] are decoded
- PWDATA  in  32  APB write data
- PREADY  out  1  constant 1, so there are no wait states
- PSLVERR  out  1  1 during the access phase to offset 7 (unmapped), else 0
- PRDATA  out  32  read data, combinational from PADDR[4:2]
- x_pulse_width  out  PW_W  commanded X pulse width
- y_pulse_width  out  PW_W  commanded Y pulse width
- frame_strobe  out  1  one-cycle pulse in the cycle the pulse widths update

## Operation
- CENTER = (PW_MIN+PW_MAX)/2, using integer division.
- **Register map.** The offset is PADDR[4:2].
  - 0 CTRL (RW): [1:0] mode, where 00 HOLD, 01 TRACK, 10 SWEEP and 11 is stored but behaves as HOLD. [2] RECENTER is write-1, self-clearing and reads 0.
  - 1 X_TARGET (RW) and 2 Y_TARGET (RW): [PW_W-1:0]. Writes are clamped to [PW_MIN,PW_MAX] at write time.
  - 3 STEP (RW): [15:0]. A value of 0 freezes all motion.
  - 4 STATUS (RO): [0] x_busy, [1] y_busy, [2] x_dir, [3] y_dir (1 = increasing), [4] frame parity toggle.
  - 5 X_CUR (RO) and 6 Y_CUR (RO).
  - 7 is unmapped: reads return 0 and PSLVERR = 1.
  - Unused read bits are 0. Writes to RO offsets are ignored.
- **Write commit.** A write commits when PSEL && PENABLE && PWRITE.
- **Frame counter.** It counts 0..PWM_PERIOD-1 and wraps. The tick is asserted when the count equals PWM_PERIOD-1.
- **Update on tick.** Each axis update is per axis; the X and Y updates are independent except in SWEEP.
  - HOLD: cur is unchanged.
  - TRACK: cur moves toward target by min(STEP, |target-cur|). busy = (cur != target).
  - SWEEP, X axis: next = cur ± STEP. If next ≥ PW_MAX, X is set to PW_MAX and x_dir clears. If next ≤ PW_MIN, X is set to PW_MIN and x_dir sets. Use PW_W+1-bit signed arithmetic, so there is no wrap.
  - SWEEP, Y axis: Y steps by STEP in y_dir only on a frame where X reversed, with the same clamp/reverse rule. busy = 1 in SWEEP.
- **Mode changes.** These take effect on the next tick and start from the current positions. Entering SWEEP does not reset the directions.
- **RECENTER.** In the cycle after the write, X_CUR, Y_CUR, X_TARGET and Y_TARGET are set to CENTER and both dirs are set. The mode is unchanged. It overrides a tick in the same cycle.
- **Outputs.** x_pulse_width and y_pulse_width are registered copies of cur.

## Timing
- The tick in cycle T produces new cur values and frame_strobe = 1 in cycle T+1.
- An APB write and a tick in the same cycle: the update uses register values from before the write, and the written value is visible from T+1.
- Reads return the live register. Reading X_CUR in the strobe cycle returns the new value.
- PRESET values:
  - counter 0, frame_strobe 0, PSLVERR 0, PREADY 1, PRDATA per decode
  - cur, targets and outputs = CENTER
  - STEP = 1000, mode HOLD, dirs 1, parity 0
- PRESET asserted mid-motion or mid-APB transfer aborts immediately to the reset values. No partial write commits.

## Structure
- Package servo_pkg holds:
  - register offset constants (REG_CTRL … REG_YCUR)
  - the mode enum (MODE_HOLD, MODE_TRACK, MODE_SWEEP)
  - CTRL and STATUS bit positions
  - the PW_W default
- Sub-module servo_axis_slew, instantiated twice:
  - inputs: tick, mode, target, step, step_en (Y only in SWEEP), recenter
  - outputs: cur, dir, busy, reversed
- The top level holds the APB decode, the registers, the frame counter and the X→Y reversal coupling.

## Test plan
Bench parameters: PWM_PERIOD=100, PW_MIN=10, PW_MAX=50, CENTER=30.
- Reset: hold PRESET for 3 cycles, then release. Required: both outputs 30, STEP reads 1000, CTRL reads 0, frame_strobe first pulses in cycle 101 after release.
- TRACK slew: STEP=4, X_TARGET=41, mode TRACK. Required: X goes 34, 38, 41 on successive strobes, then x_busy = 0; Y stays at 30.
- Clamp: write X_TARGET=5 then 999. Required: they read back 10 and 50 respectively.
- SWEEP raster: STEP=10, mode SWEEP, from (30,30). Required: X goes 40, 50 (reverse); Y becomes 40 on that same strobe; then X goes 40, 30, 20, 10 (reverse) and Y becomes 50 (reverse).
- Tick/write collision: write STEP=2 in the tick cycle with STEP previously 4. Required: that update moves by 4 and the next update moves by 2.
- Errors and recenter: a read of offset 7 gives PSLVERR = 1 and PRDATA = 0. Writing RECENTER mid-sweep gives X_CUR = Y_CUR = 30 in the next cycle, with the mode still SWEEP.
